// File: rtl/axi4_w_drop_gate.sv
// rtl/axi4_w_drop_gate.sv - W-channel gate that forwards or drops bursts per AW-side decision
module axi4_w_drop_gate #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_USER_WIDTH = 2,
    parameter int DEC_DEPTH      = 4
) (
    input  logic                        axi4_aclk,
    input  logic                        axi4_arstn,
    input  logic                        dec_valid_i,
    input  logic                        dec_drop_i,
    output logic                        dec_ready_o,
    input  logic [AXI_DATA_WIDTH-1:0]   s_axi4_wdata,
    input  logic                        s_axi4_wvalid,
    output logic                        s_axi4_wready,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_axi4_wstrb,
    input  logic                        s_axi4_wlast,
    input  logic [AXI_USER_WIDTH-1:0]   s_axi4_wuser,
    output logic [AXI_DATA_WIDTH-1:0]   m_axi4_wdata,
    output logic                        m_axi4_wvalid,
    input  logic                        m_axi4_wready,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axi4_wstrb,
    output logic                        m_axi4_wlast,
    output logic [AXI_USER_WIDTH-1:0]   m_axi4_wuser,
    output logic                        drop_done_o,
    output logic [15:0]                 drop_cnt_o
);
    localparam int PTR_W = $clog2(DEC_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEC_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t               state;
    logic [DEC_DEPTH-1:0] dec_mem;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [CNT_W-1:0]     count_next;
    logic                 dec_ready_q;
    logic                 push;
    logic                 pop;
    logic                 drop_done_q;
    logic [15:0]          drop_cnt_q;

    // Ready is registered, so a pop while full only frees space from the next cycle on.
    assign push = dec_valid_i & dec_ready_q;
    // Only IDLE consumes a decision; count reflects last edge, so no same-cycle bypass.
    assign pop  = (state == IDLE) && (count != '0);

    // Occupancy after this edge, used for both the counter and the registered ready.
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (!push && pop) begin
            count_next = count - CNT_W'(1);
        end
    end

    // Decision FIFO storage, pointers, occupancy and registered ready.
    always_ff @(posedge axi4_aclk) begin
        if (!axi4_arstn) begin
            dec_mem     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            dec_ready_q <= 1'b1;
        end else begin
            if (push) begin
                dec_mem[wr_ptr] <= dec_drop_i;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count       <= count_next;
            dec_ready_q <= (count_next != FULL_CNT);
        end
    end

    // Burst state machine; the drop-completion pulse and counter update on the last dropped beat.
    always_ff @(posedge axi4_aclk) begin
        if (!axi4_arstn) begin
            state       <= IDLE;
            drop_done_q <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            drop_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        state <= dec_mem[rd_ptr] ? DROP : FWD;
                    end
                end
                FWD: begin
                    if (s_axi4_wvalid && m_axi4_wready && s_axi4_wlast) begin
                        state <= IDLE;
                    end
                end
                DROP: begin
                    if (s_axi4_wvalid && s_axi4_wlast) begin
                        state       <= IDLE;
                        drop_done_q <= 1'b1;
                        if (drop_cnt_q != 16'hFFFF) begin
                            drop_cnt_q <= drop_cnt_q + 16'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Payload always follows upstream; it is only meaningful while m_axi4_wvalid is high.
    assign m_axi4_wdata  = s_axi4_wdata;
    assign m_axi4_wstrb  = s_axi4_wstrb;
    assign m_axi4_wlast  = s_axi4_wlast;
    assign m_axi4_wuser  = s_axi4_wuser;
    assign m_axi4_wvalid = (state == FWD) && s_axi4_wvalid;
    assign s_axi4_wready = (state == FWD) ? m_axi4_wready : (state == DROP);

    assign dec_ready_o = dec_ready_q;
    assign drop_done_o = drop_done_q;
    assign drop_cnt_o  = drop_cnt_q;

endmodule
